flag_recover: RTL and testbench
===============================

FLAG_RECOVER -- requirements
Module: flag_recover

Interface
REQ-001 The parameter list SHALL be: WIDTH, 256, operand/result width in bits.
REQ-002 The parameter list SHALL be: SLICE, 16, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request carries valid operands.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 target  input  WIDTH  minuend, the expected checker output.
REQ-009 addend  input  WIDTH  subtrahend, the checker's additive constant.
REQ-010 borrow_in  input  1  borrow into the least-significant slice (mirrors the checker's carry-in).
REQ-011 out_valid  output  1  result and borrow_out are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  WIDTH  (target - addend - borrow_in) mod 2^WIDTH.
REQ-014 borrow_out  output  1  1 when target < addend + borrow_in.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 On an IDLE cycle with in_valid=1, the block SHALL register target, addend and borrow_in, clear the slice index to 0, load the borrow register with borrow_in, and enter RUN.
REQ-018 Each RUN cycle k (0..WIDTH/SLICE-1) SHALL compute slice k of the result as target[k] - addend[k] - borrow, write that slice into the result register, and update the borrow register with the slice borrow.
REQ-019 Slices SHALL be processed LSB slice first, with exactly one slice per cycle and no skipped or repeated slices.
REQ-020 After slice WIDTH/SLICE-1 the block SHALL enter DONE and drive borrow_out with the final borrow.
REQ-021 Latency SHALL be fixed: out_valid rises on the edge WIDTH/SLICE+1 cycles after the accepting edge (17 cycles at the default parameters), independent of the data.
REQ-022 In DONE, result and borrow_out SHALL hold stable until the cycle in which out_valid and out_ready are both 1; the block then returns to IDLE.
REQ-023 In DONE with out_ready=0 the block SHALL stall indefinitely, with no change to any output.
REQ-024 in_valid asserted during RUN or DONE SHALL be ignored, and neither the operand registers nor the state SHALL change.
REQ-025 The input operands SHALL be sampled only on the accepting edge; input changes during RUN SHALL NOT affect the result.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH, with the borrow out of the top slice reported only on borrow_out.
REQ-027 The result register SHALL be visible on result in all states, but is defined only while out_valid=1.

Reset
REQ-028 While rst_n=0 the block SHALL be in IDLE, and the outputs SHALL be in_ready=1, out_valid=0, result=0, borrow_out=0; the slice index and borrow register SHALL be 0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation immediately, asynchronously, with no partial result delivered.
REQ-030 After reset release, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-031 Wrap case: target=0, addend=1, borrow_in=0 -> result=all ones (2^256-1), borrow_out=1, out_valid exactly 17 cycles after accept.
REQ-032 Borrow ripple across a slice boundary: target=0x10000, addend=1, borrow_in=0 -> result=0xFFFF, borrow_out=0; a second case with target=2^255 and addend=1 -> result=2^255-1, borrow_out=0, exercising a borrow through all 16 slices.
REQ-033 Equal operands: target=addend=2^256-1, borrow_in=1 -> result=all ones, borrow_out=1; with borrow_in=0 -> result=0, borrow_out=0.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid and target -> result, borrow_out and out_valid stay constant and in_ready stays 0; raising out_ready gives IDLE on the next cycle.
REQ-035 Abort: assert rst_n=0 during the 8th RUN cycle -> out_valid=0, result=0 and in_ready=1 immediately; a new request after release gives the correct result in 17 cycles.
REQ-036 Round trip: for 1000 random (flag, addend) pairs, apply target = flag + addend to the block -> result = flag with borrow_out = 0.

Source files
------------

// File: rtl/flag_recover.sv
// Slice-serial subtractor: recovers (target - addend - borrow_in) one SLICE per
// cycle, LSB slice first, with a valid/ready handshake on both sides.
module flag_recover #(
  parameter int WIDTH = 256,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] addend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = $clog2(NSLICE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [WIDTH-1:0]  add_q, add_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic              borrow_out_q, borrow_out_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [SLICE-1:0]  t_slice;
  logic [SLICE-1:0]  a_slice;
  logic [SLICE:0]    diff;

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    add_d        = add_q;
    res_d        = res_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    t_slice      = '0;
    a_slice      = '0;

    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IDXW'(k)) begin
        t_slice = tgt_q[k*SLICE +: SLICE];
        a_slice = add_q[k*SLICE +: SLICE];
      end else begin
      end
    end
    // Top bit of the widened difference is the borrow out of this slice.
    diff = {1'b0, t_slice} - {1'b0, a_slice} - {{SLICE{1'b0}}, borrow_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tgt_d      = target;
          add_d      = addend;
          borrow_d   = borrow_in;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end else begin
        end
      end
      RUN: begin
        // One extra cycle once all slices are done publishes the final borrow.
        if (idx_q == IDXW'(NSLICE)) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          borrow_out_d = borrow_q;
        end else begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) begin
              res_d[k*SLICE +: SLICE] = diff[SLICE-1:0];
            end else begin
            end
          end
          borrow_d = diff[SLICE];
          idx_d    = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      add_q        <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      add_q        <= add_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = res_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_flag_recover.sv
// Scoreboard bench for flag_recover: driver pushes expected results, a negedge
// monitor pops and compares them when out_valid rises.
module tb_flag_recover;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] target;
  logic [255:0] addend;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] result;
  logic         borrow_out;

  flag_recover #(.WIDTH(256), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .target(target), .addend(addend), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] res;
    logic         bo;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compares on the rising out_valid, then checks stability while held.
  initial begin
    exp_t cur;
    logic prev_ov;
    prev_ov = 1'b0;
    cur = '{res: '0, bo: 1'b0, acc: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 256'(out_valid), 256'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("result", result, cur.res);
            chk("borrow_out", 256'(borrow_out), 256'(cur.bo));
            chk("latency", 256'(cyc), 256'(cur.acc + 17));
            chk("in_ready_in_done", 256'(in_ready), 256'd0);
          end
        end else if (out_valid && prev_ov) begin
          chk("hold_result", result, cur.res);
          chk("hold_borrow_out", 256'(borrow_out), 256'(cur.bo));
          chk("hold_in_ready", 256'(in_ready), 256'd0);
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic do_req(input logic [255:0] t, input logic [255:0] a, input logic b,
                        input logic [255:0] er, input logic eb);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 256'(in_ready), 256'd1);
      return;
    end
    target = t; addend = a; borrow_in = b; in_valid = 1'b1;
    exp_q.push_back('{res: er, bo: eb, acc: cyc + 1});
    @(negedge clk);
    // Junk operands and a stray in_valid during RUN must be ignored.
    target = rnd256(); addend = rnd256(); borrow_in = 1'($urandom);
    in_valid = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    target = rnd256();
  endtask

  task automatic model_req(input logic [255:0] t, input logic [255:0] a, input logic b);
    logic [256:0] d;
    d = {1'b0, t} - {1'b0, a} - 257'(b);
    do_req(t, a, b, d[255:0], d[256]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] top;
    logic [255:0] flag;
    logic [255:0] a;
    int n;
    ones = '1;
    top  = 256'd1 << 255;
    rst_n = 1'b0; in_valid = 1'b0; target = '0; addend = '0;
    borrow_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_result", result, 256'd0);
    chk("rst_borrow_out", 256'(borrow_out), 256'd0);
    rst_n = 1'b1;

    do_req(256'd0, 256'd1, 1'b0, ones, 1'b1);
    do_req(256'h10000, 256'd1, 1'b0, 256'hFFFF, 1'b0);
    do_req(top, 256'd1, 1'b0, top - 256'd1, 1'b0);
    do_req(ones, ones, 1'b1, ones, 1'b1);
    do_req(ones, ones, 1'b0, 256'd0, 1'b0);
    for (int i = 0; i < 20; i++) model_req(rnd256(), rnd256(), 1'($urandom));
    drain();

    // Backpressure: hold DONE for 10 cycles while wiggling inputs.
    out_ready = 1'b0;
    model_req(rnd256(), rnd256(), 1'($urandom));
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 256'(out_valid), 256'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      target = rnd256();
      chk("bp_in_ready", 256'(in_ready), 256'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 256'(out_valid), 256'd0);
    chk("bp_release_in_ready", 256'(in_ready), 256'd1);
    drain();

    // Abort inside the 8th RUN cycle.
    model_req(rnd256(), rnd256(), 1'b0);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 256'(out_valid), 256'd0);
    chk("abort_result", result, 256'd0);
    chk("abort_in_ready", 256'(in_ready), 256'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    do_req(256'd0, 256'd1, 1'b0, ones, 1'b1);
    drain();

    // Round trip: target = flag + addend must recover flag with no borrow.
    for (int i = 0; i < 1000; i++) begin
      flag = rnd256(); flag[255] = 1'b0;
      a = rnd256(); a[255] = 1'b0;
      do_req(flag + a, a, 1'b0, flag, 1'b0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
